// File: rtl/ct_vfalu_ereg_fflags_buf.sv
// rtl/ct_vfalu_ereg_fflags_buf.sv - pending fcnvt exception-flag buffer and fflags accumulator
// Optional feature macro: CT_VFALU_EREG_OVF_EN (sticky overflow error flop)
module ct_vfalu_ereg_fflags_buf #(
    parameter int DEPTH = 4,
    parameter int IID_W = 7,
    parameter int CNT_W = 3
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             fcnvt_ereg_forward_r_vld,
    input  logic [4:0]       fcnvt_ereg_forward_result,
    input  logic [IID_W-1:0] dp_vfalu_ex3_pipex_iid,
    input  logic             rtu_vfpu_commit_vld,
    input  logic [IID_W-1:0] rtu_vfpu_commit_iid,
    input  logic             rtu_yy_xx_flush,
    input  logic             cp0_vfpu_fflags_clr,
    output logic             vfalu_ereg_full,
    output logic [CNT_W-1:0] vfalu_ereg_entry_cnt,
    output logic [4:0]       vfalu_cp0_fflags,
    output logic             vfalu_cp0_fflags_upd,
    output logic             vfalu_ereg_ovf_err
);

    logic [DEPTH-1:0] r_vld;
    logic [IID_W-1:0] r_iid   [DEPTH];
    logic [4:0]       r_flags [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic             r_full;
    logic [4:0]       r_fflags;
    logic             r_upd;

    logic             w_nz;
    logic             w_byp;
    logic [DEPTH-1:0] w_match;
    logic [4:0]       w_cmt_flags;
    logic             w_cmt_hit;
    logic             w_alloc_req;
    logic [DEPTH-1:0] w_alloc_oh;
    logic             w_found;
    logic [DEPTH-1:0] w_vld_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Commit matching, bypass detection, lowest-free slot pick and next-state valid vector.
    // The free-slot search looks only at the current valid bits, so a slot being
    // freed by this cycle's commit is not handed out until the following cycle.
    always_comb begin
        w_nz        = fcnvt_ereg_forward_r_vld && (fcnvt_ereg_forward_result != 5'b0);
        w_byp       = rtu_vfpu_commit_vld && w_nz &&
                      (rtu_vfpu_commit_iid == dp_vfalu_ex3_pipex_iid);
        w_match     = '0;
        w_cmt_flags = w_byp ? fcnvt_ereg_forward_result : 5'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_vld[i] && rtu_vfpu_commit_vld && (r_iid[i] == rtu_vfpu_commit_iid);
            if (w_match[i]) begin
                w_cmt_flags = w_cmt_flags | r_flags[i];
            end
        end
        w_cmt_hit   = (|w_match) || w_byp;
        w_alloc_req = w_nz && !w_byp && !rtu_yy_xx_flush;
        w_alloc_oh  = '0;
        w_found     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_vld[i] && !w_found) begin
                w_alloc_oh[i] = 1'b1;
                w_found       = 1'b1;
            end
        end
        if (rtu_yy_xx_flush) begin
            w_vld_nxt = '0;
        end else begin
            w_vld_nxt = (r_vld & ~w_match) | (w_alloc_req ? w_alloc_oh : '0);
        end
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_vld_nxt[i]);
        end
    end

    // Entry valid bits and registered count/full derived from the next-state vector.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_vld  <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_vld  <= w_vld_nxt;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CNT_W'(DEPTH));
        end
    end

    // Entry payload capture into the slot chosen for allocation.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_iid[i]   <= '0;
                r_flags[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_req && w_alloc_oh[i]) begin
                    r_iid[i]   <= dp_vfalu_ex3_pipex_iid;
                    r_flags[i] <= fcnvt_ereg_forward_result;
                end
            end
        end
    end

    // Architectural accumulator: a CSR clear wipes old flags but keeps this cycle's commit.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_fflags <= '0;
            r_upd    <= 1'b0;
        end else begin
            r_fflags <= cp0_vfpu_fflags_clr ? w_cmt_flags : (r_fflags | w_cmt_flags);
            r_upd    <= w_cmt_hit;
        end
    end

`ifdef CT_VFALU_EREG_OVF_EN
    logic r_ovf;
    logic w_ovf_set;

    assign w_ovf_set = w_alloc_req && (&r_vld);

    // Sticky overflow: only reset clears it, flush leaves it set.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end
    end

    assign vfalu_ereg_ovf_err = r_ovf;
`else
    assign vfalu_ereg_ovf_err = 1'b0;
`endif

    assign vfalu_ereg_full      = r_full;
    assign vfalu_ereg_entry_cnt = r_cnt;
    assign vfalu_cp0_fflags     = r_fflags;
    assign vfalu_cp0_fflags_upd = r_upd;

endmodule

// File: tb/tb_ct_vfalu_ereg_fflags_buf.sv
// tb/tb_ct_vfalu_ereg_fflags_buf.sv - table, corner-case and randomized checks of the fflags buffer
module tb_ct_vfalu_ereg_fflags_buf;

`ifdef CT_VFALU_EREG_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       rv;
    logic [4:0] res;
    logic [6:0] eiid;
    logic       cv;
    logic [6:0] ciid;
    logic       fl;
    logic       clr;
    logic       full;
    logic [2:0] cnt;
    logic [4:0] ff;
    logic       upd;
    logic       ovf;

    ct_vfalu_ereg_fflags_buf #(.DEPTH(4), .IID_W(7), .CNT_W(3)) dut (
        .forever_cpuclk            (clk),
        .cpurst_b                  (rst_n),
        .fcnvt_ereg_forward_r_vld  (rv),
        .fcnvt_ereg_forward_result (res),
        .dp_vfalu_ex3_pipex_iid    (eiid),
        .rtu_vfpu_commit_vld       (cv),
        .rtu_vfpu_commit_iid       (ciid),
        .rtu_yy_xx_flush           (fl),
        .cp0_vfpu_fflags_clr       (clr),
        .vfalu_ereg_full           (full),
        .vfalu_ereg_entry_cnt      (cnt),
        .vfalu_cp0_fflags          (ff),
        .vfalu_cp0_fflags_upd      (upd),
        .vfalu_ereg_ovf_err        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [4:0] res;
        logic [6:0] eiid;
        logic       cv;
        logic [6:0] ciid;
        logic       fl;
        logic       clr;
        logic [2:0] cnt;
        logic       full;
        logic [4:0] ff;
        logic       upd;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [6:0] iid;
        logic [4:0] fl;
    } ent_t;

    // Reference model: pending flags kept as an unordered list of (iid, flags) records.
    ent_t       q[$];
    logic [4:0] m_acc;
    logic       m_upd;
    logic       m_ovf;

    int n_vec;
    int n_err;
    vec_t tbl[18];

    function automatic vec_t mk(input logic a_rv, input logic [4:0] a_res, input logic [6:0] a_eiid,
                                input logic a_cv, input logic [6:0] a_ciid, input logic a_fl,
                                input logic a_clr, input logic [2:0] a_cnt, input logic a_full,
                                input logic [4:0] a_ff, input logic a_upd, input logic a_ovf);
        vec_t v;
        v.rv = a_rv; v.res = a_res; v.eiid = a_eiid; v.cv = a_cv; v.ciid = a_ciid;
        v.fl = a_fl; v.clr = a_clr; v.cnt = a_cnt; v.full = a_full; v.ff = a_ff;
        v.upd = a_upd; v.ovf = a_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] e_cnt, input logic e_full,
                         input logic [4:0] e_ff, input logic e_upd, input logic e_ovf);
        n_vec++;
        if (cnt !== e_cnt || full !== e_full || ff !== e_ff || upd !== e_upd || ovf !== e_ovf) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d full=%b ff=%b upd=%b ovf=%b, expected cnt=%0d full=%b ff=%b upd=%b ovf=%b",
                     name, cnt, full, ff, upd, ovf, e_cnt, e_full, e_ff, e_upd, e_ovf);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same cycle, sample #1 after the edge.
    task automatic step(input logic a_rv, input logic [4:0] a_res, input logic [6:0] a_eiid,
                        input logic a_cv, input logic [6:0] a_ciid, input logic a_fl, input logic a_clr);
        logic       nz, byp, hit;
        logic [4:0] cf;
        int         pre;
        ent_t       nq[$];
        ent_t       e;
        rv = a_rv; res = a_res; eiid = a_eiid; cv = a_cv; ciid = a_ciid; fl = a_fl; clr = a_clr;
        nz  = a_rv && (a_res != 5'b0);
        byp = a_cv && nz && (a_ciid == a_eiid);
        cf  = byp ? a_res : 5'b0;
        hit = byp;
        pre = q.size();
        nq.delete();
        foreach (q[k]) begin
            if (a_cv && q[k].iid == a_ciid) begin
                cf  = cf | q[k].fl;
                hit = 1'b1;
            end else begin
                nq.push_back(q[k]);
            end
        end
        if (nz && !byp && !a_fl) begin
            if (pre < DEPTH) begin
                e.iid = a_eiid;
                e.fl  = a_res;
                nq.push_back(e);
            end else if (OVF_EN) begin
                m_ovf = 1'b1;
            end
        end
        if (a_fl) nq.delete();
        q     = nq;
        m_acc = a_clr ? cf : (m_acc | cf);
        m_upd = hit;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        check(name, 3'(q.size()), q.size() == DEPTH, m_acc, m_upd, m_ovf);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_acc = '0; m_upd = 1'b0; m_ovf = 1'b0;
        rv = 0; res = 0; eiid = 0; cv = 0; ciid = 0; fl = 0; clr = 0;
        rst_n = 1'b0;
        #12;
        check("reset_state", 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //          rv res       eiid cv ciid fl clr  cnt full ff        upd ovf
        tbl[0]  = mk(1, 5'b00001, 5, 0, 0, 0, 0, 3'd1, 0, 5'b00000, 0, 0);
        tbl[1]  = mk(0, 5'b00000, 0, 1, 5, 0, 0, 3'd0, 0, 5'b00001, 1, 0);
        tbl[2]  = mk(0, 5'b00000, 0, 0, 0, 0, 1, 3'd0, 0, 5'b00000, 0, 0);
        tbl[3]  = mk(1, 5'b10000, 1, 0, 0, 0, 0, 3'd1, 0, 5'b00000, 0, 0);
        tbl[4]  = mk(1, 5'b01000, 2, 0, 0, 0, 0, 3'd2, 0, 5'b00000, 0, 0);
        tbl[5]  = mk(1, 5'b00100, 3, 0, 0, 0, 0, 3'd3, 0, 5'b00000, 0, 0);
        tbl[6]  = mk(1, 5'b00010, 4, 0, 0, 0, 0, 3'd4, 1, 5'b00000, 0, 0);
        tbl[7]  = mk(1, 5'b00001, 6, 0, 0, 0, 0, 3'd4, 1, 5'b00000, 0, 1);
        tbl[8]  = mk(0, 5'b00000, 0, 1, 3, 0, 0, 3'd3, 0, 5'b00100, 1, 1);
        tbl[9]  = mk(1, 5'b00001, 9, 1, 9, 0, 0, 3'd3, 0, 5'b00101, 1, 1);
        tbl[10] = mk(1, 5'b00000, 7, 0, 0, 0, 0, 3'd3, 0, 5'b00101, 0, 1);
        tbl[11] = mk(0, 5'b00000, 0, 1, 1, 1, 0, 3'd0, 0, 5'b10101, 1, 1);
        tbl[12] = mk(0, 5'b00000, 0, 1, 2, 0, 0, 3'd0, 0, 5'b10101, 0, 1);
        tbl[13] = mk(1, 5'b00010, 8, 0, 0, 0, 0, 3'd1, 0, 5'b10101, 0, 1);
        tbl[14] = mk(1, 5'b01010, 10, 1, 10, 0, 0, 3'd1, 0, 5'b11111, 1, 1);
        tbl[15] = mk(0, 5'b00000, 0, 1, 8, 0, 1, 3'd0, 0, 5'b00010, 1, 1);
        tbl[16] = mk(0, 5'b00000, 0, 0, 0, 0, 1, 3'd0, 0, 5'b00000, 0, 1);
        tbl[17] = mk(1, 5'b00100, 12, 0, 0, 1, 0, 3'd0, 0, 5'b00000, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rv, tbl[i].res, tbl[i].eiid, tbl[i].cv, tbl[i].ciid, tbl[i].fl, tbl[i].clr);
            check($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].full, tbl[i].ff, tbl[i].upd,
                  tbl[i].ovf & OVF_EN);
        end

        // Full buffer: commit frees one slot while a new allocation arrives; it must be dropped.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 5'(1 << i), 7'(20 + i), 0, 0, 0, 0);
        end
        check("refill_full", 3'd4, 1'b1, 5'b0, 1'b0, OVF_EN);
        step(1, 5'b00001, 7'd30, 1, 7'd21, 0, 0);
        check("free_and_alloc_full", 3'd3, 1'b0, 5'b00010, 1'b1, OVF_EN);
        step(1, 5'b00001, 7'd30, 0, 0, 0, 0);
        check("alloc_after_free", 3'd4, 1'b1, 5'b00010, 1'b0, OVF_EN);
        step(0, 0, 0, 0, 0, 1, 1);
        check("flush_clr", 3'd0, 1'b0, 5'b0, 1'b0, OVF_EN);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic       r_rv, r_cv, r_fl, r_clr;
            logic [4:0] r_res;
            logic [6:0] r_eiid, r_ciid;
            r_rv   = ($urandom_range(0, 99) < 60);
            r_res  = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom);
            r_eiid = 7'($urandom_range(0, 7));
            r_cv   = ($urandom_range(0, 99) < 40);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                r_ciid = q[$urandom_range(0, q.size() - 1)].iid;
            else if ($urandom_range(0, 99) < 15)
                r_ciid = r_eiid;
            else
                r_ciid = 7'($urandom_range(0, 7));
            r_fl  = ($urandom_range(0, 99) < 4);
            r_clr = ($urandom_range(0, 99) < 5);
            step(r_rv, r_res, r_eiid, r_cv, r_ciid, r_fl, r_clr);
            check_model($sformatf("rand%0d", n));
        end

        // Asynchronous reset mid-cycle while a commit is presented: nothing must survive.
        step(1, 5'b00011, 7'd40, 0, 0, 0, 0);
        rv = 0; cv = 1; ciid = 7'd40;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);
        q.delete();
        m_acc = '0; m_upd = 1'b0; m_ovf = 1'b0;
        cv = 0;
        #3;
        rst_n = 1'b1;
        step(0, 0, 0, 1, 7'd40, 0, 0);
        check_model("post_reset_commit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ct_vfalu_ereg_fflags_buf.md
Name: ct_vfalu_ereg_fflags_buf

Overview:
- Downstream consumer of the fcnvt ereg forward path.
- Captures per-instruction exception flags (NV,DZ,OF,UF,NX in bits [4:0]) that the converter produces in EX3, and holds them until the retire unit commits or flushes that instruction.
- On commit, ORs the held flags into the architectural fflags accumulator that feeds CP0.
- Sits between the vfalu pipe-x EX3 forward outputs and CP0 fcsr update logic.

Parameters:
DEPTH, 4, number of pending-flag entries (2..8).
IID_W, 7, instruction id width.
CNT_W, 3, entry count width; must satisfy CNT_W >= clog2(DEPTH+1).

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  asynchronous active-low reset
fcnvt_ereg_forward_r_vld  in  1  EX3 flag result valid
fcnvt_ereg_forward_result  in  5  EX3 exception flags
dp_vfalu_ex3_pipex_iid  in  IID_W  iid of the EX3 instruction
rtu_vfpu_commit_vld  in  1  commit strobe
rtu_vfpu_commit_iid  in  IID_W  committing iid
rtu_yy_xx_flush  in  1  pipeline flush
cp0_vfpu_fflags_clr  in  1  CSR write clears accumulator
vfalu_ereg_full  out  1  all entries valid; upstream must not issue a new fcnvt
vfalu_ereg_entry_cnt  out  CNT_W  number of valid entries
vfalu_cp0_fflags  out  5  accumulated fflags
vfalu_cp0_fflags_upd  out  1  one-cycle pulse when accumulator changed by a commit
vfalu_ereg_ovf_err  out  1  sticky overflow error (optional feature)

Behaviour:
- Reset: all entry valid bits, flags, and iids = 0. All outputs = 0.
- Entry state: valid, iid[IID_W-1:0], flags[4:0].
- Allocation: happens on r_vld when result != 0. Writes the lowest-index free entry on the next clock edge. r_vld with result == 0 allocates nothing.
- Commit:
  - Compare commit_iid against all valid entries.
  - Every matching entry is freed and its flags are ORed into the accumulator at the next edge.
  - fflags_upd is asserted for that same cycle, only if at least one entry matched.
  - A commit with no match has no effect.
- Bypass: commit_vld with commit_iid == incoming EX3 iid and r_vld with nonzero result in the same cycle:
  - Incoming flags OR directly into the accumulator.
  - No entry is allocated.
  - fflags_upd pulses.
- Flush:
  - All entries are cleared at the next edge.
  - An allocation in the same cycle is dropped.
  - A commit in the same cycle is processed first: its matched flags still accumulate and upd pulses, then the entries clear.
- fflags_clr:
  - Accumulator <= 0.
  - If a commit or bypass occurs in the same cycle, accumulator <= committed flags only (clear, then OR).
  - upd pulses only for the commit portion.
- Simultaneous commit-free and allocate: the freed slot is not reusable until the next cycle. Allocation uses free slots as of the current cycle.
- full = (entry_cnt == DEPTH), registered from the next-state count. entry_cnt is registered.
- Allocation while full: the entry is dropped and the accumulator is unaffected.
- Latency: r_vld -> entry visible in entry_cnt, 1 cycle. commit -> fflags/upd, 1 cycle.
- Reset mid-operation: asynchronous clear of everything, with no partial commit.

Optional Feature:
- Macro: CT_VFALU_EREG_OVF_EN.
- Defined: vfalu_ereg_ovf_err is set when an allocation is attempted while full and not flushed that cycle. It stays 1 until reset (flush does not clear it).
- Undefined: vfalu_ereg_ovf_err is tied to 0 and its flop is removed. Drop behaviour on overflow is unchanged.

Test Plan:
- r_vld, iid=5, result=5'b00001; next cycle commit iid=5 -> entry_cnt 1 then 0; fflags=5'b00001; upd pulses exactly once, one cycle after commit.
- Allocate iids 1,2,3,4 with flags 10000,01000,00100,00010 -> full=1 after the 4th. Commit iid=3 -> fflags=00100, full=0, cnt=3.
- Same cycle r_vld iid=9 result=00001 and commit iid=9 -> cnt stays 0; fflags |= 00001; upd=1.
- Entries iid 1,2 valid; flush together with commit iid=1 (flags 10000) -> fflags=10000, upd=1, cnt=0; a later commit iid=2 has no effect.
- fflags=11111, then clr with commit of an entry holding 00010 -> fflags=00010. clr alone -> 00000 with upd=0.
- With CT_VFALU_EREG_OVF_EN: fill 4 entries, then a 5th nonzero r_vld -> ovf_err=1 sticky, cnt=4, fflags unchanged. Without the macro -> ovf_err stays 0.
